// File: rtl/led_mode_controller.sv
// Push-button front end for the LED blinker: synchronize, debounce, and step
// OFF/SLOW/MED/FAST/AUTO, driving the blinker's rate-select and enable gate.
module led_mode_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned DWELL_CYCLES    = 25000000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_button,
  input  logic       i_hold,
  output logic       o_switch_1,
  output logic       o_switch_2,
  output logic       o_enable,
  output logic [2:0] o_mode,
  output logic       o_mode_change
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned DW_W = $clog2(DWELL_CYCLES);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW_W-1:0] DW_MAX = DW_W'(DWELL_CYCLES - 1);

  localparam logic [2:0] MODE_OFF  = 3'd0;
  localparam logic [2:0] MODE_SLOW = 3'd1;
  localparam logic [2:0] MODE_MED  = 3'd2;
  localparam logic [2:0] MODE_FAST = 3'd3;
  localparam logic [2:0] MODE_AUTO = 3'd4;

  localparam logic [1:0] STEP_SLOW = 2'd0;
  localparam logic [1:0] STEP_MED  = 2'd1;
  localparam logic [1:0] STEP_FAST = 2'd2;

  localparam logic [1:0] SEL_SLOW = 2'b11;
  localparam logic [1:0] SEL_MED  = 2'b10;
  localparam logic [1:0] SEL_FAST = 2'b00;
  localparam logic [1:0] SEL_OFF  = 2'b00;

  logic            sync_1;
  logic            sync;
  logic            stable;
  logic [DB_W-1:0] db_cnt;
  logic            press;

  logic [2:0]      mode;
  logic [2:0]      mode_nxt;
  logic [1:0]      step;
  logic [1:0]      step_nxt;
  logic [DW_W-1:0] dwell;
  logic [DW_W-1:0] dwell_nxt;

  logic [1:0]      sel_nxt;
  logic            enable_nxt;
  logic            mode_change_nxt;

  // Two-flop synchronizer and debounce; press is emitted on the same edge the
  // stable level rises so the mode update lands DEBOUNCE_CYCLES+3 edges out.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_1 <= 1'b0;
      sync   <= 1'b0;
      stable <= 1'b0;
      db_cnt <= '0;
      press  <= 1'b0;
    end else begin
      sync_1 <= i_button;
      sync   <= sync_1;
      press  <= 1'b0;
      if (sync == stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_MAX) begin
        stable <= sync;
        db_cnt <= '0;
        press  <= sync;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  // State register, with the registered output stage alongside it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mode          <= MODE_OFF;
      step          <= STEP_SLOW;
      dwell         <= '0;
      o_switch_1    <= 1'b0;
      o_switch_2    <= 1'b0;
      o_enable      <= 1'b0;
      o_mode_change <= 1'b0;
    end else begin
      mode          <= mode_nxt;
      step          <= step_nxt;
      dwell         <= dwell_nxt;
      o_switch_1    <= sel_nxt[1];
      o_switch_2    <= sel_nxt[0];
      o_enable      <= enable_nxt;
      o_mode_change <= mode_change_nxt;
    end
  end

  assign o_mode = mode;

  // Next-state logic; a press always beats dwell expiry in AUTO.
  always_comb begin
    mode_nxt  = mode;
    step_nxt  = step;
    dwell_nxt = dwell;
    case (mode)
      MODE_OFF: begin
        if (press) mode_nxt = MODE_SLOW;
      end
      MODE_SLOW: begin
        if (press) mode_nxt = MODE_MED;
      end
      MODE_MED: begin
        if (press) mode_nxt = MODE_FAST;
      end
      MODE_FAST: begin
        if (press) begin
          mode_nxt  = MODE_AUTO;
          step_nxt  = STEP_SLOW;
          dwell_nxt = '0;
        end
      end
      MODE_AUTO: begin
        if (press) begin
          mode_nxt  = MODE_OFF;
          step_nxt  = STEP_SLOW;
          dwell_nxt = '0;
        end else if (!i_hold) begin
          if (dwell == DW_MAX) begin
            dwell_nxt = '0;
            case (step)
              STEP_SLOW: step_nxt = STEP_MED;
              STEP_MED:  step_nxt = STEP_FAST;
              default:   step_nxt = STEP_SLOW;
            endcase
          end else begin
            dwell_nxt = dwell + DW_W'(1);
          end
        end
      end
      default: begin
        mode_nxt  = MODE_OFF;
        step_nxt  = STEP_SLOW;
        dwell_nxt = '0;
      end
    endcase
  end

  // Output decode from next state so registered outputs track the state edge.
  always_comb begin
    sel_nxt         = SEL_OFF;
    enable_nxt      = 1'b0;
    mode_change_nxt = (mode_nxt != mode) && (mode <= MODE_AUTO);
    case (mode_nxt)
      MODE_SLOW: begin
        sel_nxt    = SEL_SLOW;
        enable_nxt = 1'b1;
      end
      MODE_MED: begin
        sel_nxt    = SEL_MED;
        enable_nxt = 1'b1;
      end
      MODE_FAST: begin
        sel_nxt    = SEL_FAST;
        enable_nxt = 1'b1;
      end
      MODE_AUTO: begin
        enable_nxt = 1'b1;
        case (step_nxt)
          STEP_SLOW: sel_nxt = SEL_SLOW;
          STEP_MED:  sel_nxt = SEL_MED;
          default:   sel_nxt = SEL_FAST;
        endcase
      end
      default: begin
        sel_nxt    = SEL_OFF;
        enable_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_led_mode_controller.sv
// Directed bench for led_mode_controller with DEBOUNCE_CYCLES=4, DWELL_CYCLES=8.
module tb_led_mode_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       button;
  logic       hold;
  logic       sw1;
  logic       sw2;
  logic       en;
  logic [2:0] mode;
  logic       mc;

  int n_cmp = 0;
  int n_err = 0;
  int walk_total = 0;

  led_mode_controller #(.DEBOUNCE_CYCLES(4), .DWELL_CYCLES(8)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_button      (button),
    .i_hold        (hold),
    .o_switch_1    (sw1),
    .o_switch_2    (sw2),
    .o_enable      (en),
    .o_mode        (mode),
    .o_mode_change (mc)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full press: high 10 cycles, low 10 cycles; checks outputs on the pulse.
  task automatic press(input logic [2:0] exp_mode, input logic [1:0] exp_sel, input logic exp_en);
    int pulses;
    pulses = 0;
    button = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) button = 1'b0;
      step();
      if (mc) begin
        pulses++;
        chk("walk_mode", 32'(mode), 32'(exp_mode));
        chk("walk_sel", 32'({sw1, sw2}), 32'(exp_sel));
        chk("walk_en", 32'(en), 32'(exp_en));
      end
    end
    walk_total += pulses;
    chk("walk_pulses", 32'(pulses), 32'd1);
  endtask

  initial begin
    logic [1:0] exp_sel;
    bit seen;

    // Reset with button held
    rst = 1'b1; button = 1'b1; hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_outputs", 32'({sw1, sw2, en, mode, mc}), 32'd0);
    end
    rst = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("lat_mode_pre", 32'(mode), 32'd0);
      chk("lat_mc_pre", 32'(mc), 32'd0);
    end
    step();
    chk("lat_mode", 32'(mode), 32'd1);
    chk("lat_mc", 32'(mc), 32'd1);
    chk("lat_sel", 32'({sw1, sw2}), 32'b11);
    chk("lat_en", 32'(en), 32'd1);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("held_mode", 32'(mode), 32'd1);
      chk("held_mc", 32'(mc), 32'd0);
    end
    button = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("release_mode", 32'(mode), 32'd1);

    // Bounce rejection
    button = 1'b1; step();
    button = 1'b0; step();
    button = 1'b1; step();
    button = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      chk("bounce_mode", 32'(mode), 32'd1);
      chk("bounce_sel", 32'({sw1, sw2}), 32'b11);
      chk("bounce_mc", 32'(mc), 32'd0);
    end

    // Return to OFF, then walk all modes
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst2_mode", 32'(mode), 32'd0);
    walk_total = 0;
    press(3'd1, 2'b11, 1'b1);
    press(3'd2, 2'b10, 1'b1);
    press(3'd3, 2'b00, 1'b1);
    press(3'd4, 2'b11, 1'b1);
    press(3'd0, 2'b00, 1'b0);
    chk("walk_total", 32'(walk_total), 32'd5);
    chk("walk_end_mode", 32'(mode), 32'd0);

    // AUTO rotation
    press(3'd1, 2'b11, 1'b1);
    press(3'd2, 2'b10, 1'b1);
    press(3'd3, 2'b00, 1'b1);
    button = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (mc) seen = 1'b1;
    end
    chk("auto_entry_seen", 32'(seen), 32'd1);
    button = 1'b0;
    chk("auto_entry_mode", 32'(mode), 32'd4);
    chk("auto_entry_sel", 32'({sw1, sw2}), 32'b11);
    for (int k = 1; k <= 24; k++) begin
      step();
      if (k < 8) exp_sel = 2'b11;
      else if (k < 16) exp_sel = 2'b10;
      else if (k < 24) exp_sel = 2'b00;
      else exp_sel = 2'b11;
      chk("auto_sel", 32'({sw1, sw2}), 32'(exp_sel));
      chk("auto_mode", 32'(mode), 32'd4);
      chk("auto_mc", 32'(mc), 32'd0);
      chk("auto_en", 32'(en), 32'd1);
    end

    // Hold mid-step: dwell frozen at 3
    for (int k = 0; k < 3; k++) step();
    hold = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("hold_sel", 32'({sw1, sw2}), 32'b11);
    end
    hold = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      step();
      exp_sel = (j < 5) ? 2'b11 : 2'b10;
      chk("resume_sel", 32'({sw1, sw2}), 32'(exp_sel));
    end

    // Press coincident with dwell expiry
    step();
    button = 1'b1;
    for (int k = 0; k < 6; k++) step();
    chk("coll_pre_mode", 32'(mode), 32'd4);
    chk("coll_pre_sel", 32'({sw1, sw2}), 32'b10);
    chk("coll_pre_mc", 32'(mc), 32'd0);
    step();
    chk("coll_mode", 32'(mode), 32'd0);
    chk("coll_sel", 32'({sw1, sw2}), 32'b00);
    chk("coll_en", 32'(en), 32'd0);
    chk("coll_mc", 32'(mc), 32'd1);
    button = 1'b0;
    for (int k = 0; k < 10; k++) step();

    // Mid-operation reset during a debounce in FAST
    press(3'd1, 2'b11, 1'b1);
    press(3'd2, 2'b10, 1'b1);
    press(3'd3, 2'b00, 1'b1);
    button = 1'b1;
    step(); step();
    rst = 1'b1; button = 1'b0;
    step();
    chk("midrst_mode", 32'(mode), 32'd0);
    chk("midrst_out", 32'({sw1, sw2, en, mc}), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 15; k++) begin
      step();
      chk("midrst_after_mode", 32'(mode), 32'd0);
      chk("midrst_after_mc", 32'(mc), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
